// File: rtl/adc_input_monitor_pkg.sv
// Shared constants, host op encoding and window-length clamp for the ADC input monitor.
package adc_input_monitor_pkg;

   localparam int unsigned ADC_BITS_DEF = 14;
   localparam int unsigned CTR_BITS_DEF = 16;
   localparam logic [4:0]  WIN_SEL_MIN  = 5'd4;

   // Host register write ops that land on the quasi-static inputs.
   typedef enum logic [1:0] {
      OpNone       = 2'b00,
      OpSetCntMask = 2'b01,
      OpSetWinSel  = 2'b10
   } host_op_e;

   function automatic logic [4:0] clamp_win(input logic [4:0] sel, input logic [4:0] sel_max);
      if (sel < WIN_SEL_MIN) return WIN_SEL_MIN;
      if (sel > sel_max) return sel_max;
      return sel;
   endfunction

endpackage

// File: rtl/adc_input_monitor_if.sv
// ADC sample stream, host controls and monitor results for the ADC input monitor.
interface adc_input_monitor_if
   import adc_input_monitor_pkg::*;
#(
   parameter int unsigned ADC_BITS = ADC_BITS_DEF,
   parameter int unsigned CTR_BITS = CTR_BITS_DEF
);

   logic signed [ADC_BITS-1:0] adc_data_in;
   logic                       adc_ovfl_in;
   logic [CTR_BITS-1:0]        cnt_mask;
   logic [4:0]                 win_sel;
   logic                       peak_clr;
   logic signed [ADC_BITS-1:0] adc_data_out;
   logic                       ovfl_pulse;
   logic [CTR_BITS-1:0]        ovfl_count;
   logic [ADC_BITS-2:0]        peak_abs;

   modport master (
      output adc_data_in, adc_ovfl_in, cnt_mask, win_sel, peak_clr,
      input  adc_data_out, ovfl_pulse, ovfl_count, peak_abs
   );

   modport slave (
      input  adc_data_in, adc_ovfl_in, cnt_mask, win_sel, peak_clr,
      output adc_data_out, ovfl_pulse, ovfl_count, peak_abs
   );

endinterface

// File: rtl/adc_input_monitor_ovfl_window_ctr.sv
// Sample window counter, saturating overflow accumulator and end-of-window mask compare.
module adc_input_monitor_ovfl_window_ctr
   import adc_input_monitor_pkg::*;
#(
   parameter int unsigned CTR_BITS = CTR_BITS_DEF
) (
   input  logic                adc_clk,
   input  logic                rst_n,
   input  logic                ovfl,
   input  logic [CTR_BITS-1:0] cnt_mask,
   input  logic [4:0]          win_sel,
   output logic                ovfl_pulse,
   output logic [CTR_BITS-1:0] ovfl_count
);

   logic [CTR_BITS:0]   samp_ctr_q, samp_ctr_d, win_last;
   logic [4:0]          win_eff_q, win_cur;
   logic [CTR_BITS-1:0] acc_q, acc_d, total, count_q, count_d;
   logic                pulse_q, pulse_d, win_end;

   // win_sel is only looked at on the first sample of a window.
   assign win_cur  = (samp_ctr_q == '0) ? clamp_win(win_sel, 5'(CTR_BITS)) : win_eff_q;
   assign win_last = ((CTR_BITS+1)'(1) << win_cur) - (CTR_BITS+1)'(1);
   assign win_end  = (samp_ctr_q == win_last);
   assign total    = (ovfl && acc_q != '1) ? acc_q + CTR_BITS'(1) : acc_q;

   always_comb begin
      samp_ctr_d = samp_ctr_q + (CTR_BITS+1)'(1);
      acc_d      = total;
      count_d    = count_q;
      pulse_d    = 1'b0;
      if (win_end) begin
         samp_ctr_d = '0;
         acc_d      = '0;
         count_d    = total;
         pulse_d    = |(total & cnt_mask);
      end
   end

   always_ff @(posedge adc_clk or negedge rst_n) begin
      if (!rst_n) begin
         samp_ctr_q <= '0;
         win_eff_q  <= '0;
         acc_q      <= '0;
         count_q    <= '0;
         pulse_q    <= 1'b0;
      end else begin
         samp_ctr_q <= samp_ctr_d;
         win_eff_q  <= win_cur;
         acc_q      <= acc_d;
         count_q    <= count_d;
         pulse_q    <= pulse_d;
      end
   end

   assign ovfl_pulse = pulse_q;
   assign ovfl_count = count_q;

endmodule

// File: rtl/adc_input_monitor.sv
// ADC front end: registers samples, tracks peak |sample| and flags windowed overflow counts.
module adc_input_monitor
   import adc_input_monitor_pkg::*;
#(
   parameter int unsigned ADC_BITS = ADC_BITS_DEF,
   parameter int unsigned CTR_BITS = CTR_BITS_DEF
) (
   input logic                adc_clk,
   input logic                rst_n,
   adc_input_monitor_if.slave bus
);

   localparam logic [ADC_BITS-1:0] MinSample = {1'b1, {(ADC_BITS-1){1'b0}}};

   logic signed [ADC_BITS-1:0] data_q;
   logic [ADC_BITS-2:0]        abs_s, peak_q, peak_d;

   // The most negative code has no positive twin; it saturates to full scale.
   always_comb begin
      if (!bus.adc_data_in[ADC_BITS-1]) begin
         abs_s = bus.adc_data_in[ADC_BITS-2:0];
      end else if ($unsigned(bus.adc_data_in) == MinSample) begin
         abs_s = '1;
      end else begin
         abs_s = ~bus.adc_data_in[ADC_BITS-2:0] + (ADC_BITS-1)'(1);
      end
      peak_d = peak_q;
      if (bus.peak_clr || abs_s > peak_q) peak_d = abs_s;
   end

   always_ff @(posedge adc_clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= '0;
         peak_q <= '0;
      end else begin
         data_q <= bus.adc_data_in;
         peak_q <= peak_d;
      end
   end

   assign bus.adc_data_out = data_q;
   assign bus.peak_abs     = peak_q;

   adc_input_monitor_ovfl_window_ctr #(
      .CTR_BITS(CTR_BITS)
   ) u_ovfl_window_ctr (
      .adc_clk   (adc_clk),
      .rst_n     (rst_n),
      .ovfl      (bus.adc_ovfl_in),
      .cnt_mask  (bus.cnt_mask),
      .win_sel   (bus.win_sel),
      .ovfl_pulse(bus.ovfl_pulse),
      .ovfl_count(bus.ovfl_count)
   );

endmodule

// File: tb/tb_adc_input_monitor.sv
// Directed bench for adc_input_monitor: windowing, masking, saturation, peak and reset.
module tb_adc_input_monitor;

   logic adc_clk = 1'b0;
   logic rst_n;
   int   n_cmp = 0;
   int   n_bad = 0;

   adc_input_monitor_if bus ();

   adc_input_monitor dut (
      .adc_clk(adc_clk),
      .rst_n  (rst_n),
      .bus    (bus)
   );

   always #5 adc_clk = ~adc_clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // One sample: drive, clock it in, look just after the edge.
   task automatic tick(input logic signed [13:0] d, input logic ov, input logic clr);
      bus.adc_data_in = d;
      bus.adc_ovfl_in = ov;
      bus.peak_clr    = clr;
      @(posedge adc_clk);
      #1;
      check_eq("data_out", 32'(bus.adc_data_out), 32'(d));
   endtask

   // One aligned 16-sample window; pat[i] is the overflow flag of sample i.
   task automatic win16(input logic [15:0] pat, input logic [15:0] exp_cnt, input logic exp_pulse,
                        input string tag);
      for (int i = 0; i < 16; i++) begin
         tick(14'(i * 37 - 200), pat[i], 1'b0);
         if (i < 15) check_eq({tag, "_pulse_mid"}, 32'(bus.ovfl_pulse), 32'd0);
      end
      check_eq({tag, "_count"}, 32'(bus.ovfl_count), 32'(exp_cnt));
      check_eq({tag, "_pulse"}, 32'(bus.ovfl_pulse), 32'(exp_pulse));
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_data_out"}, 32'(bus.adc_data_out), 32'd0);
      check_eq({tag, "_pulse"}, 32'(bus.ovfl_pulse), 32'd0);
      check_eq({tag, "_count"}, 32'(bus.ovfl_count), 32'd0);
      check_eq({tag, "_peak"}, 32'(bus.peak_abs), 32'd0);
   endtask

   initial begin
      rst_n           = 1'b0;
      bus.adc_data_in = '0;
      bus.adc_ovfl_in = 1'b0;
      bus.peak_clr    = 1'b0;
      bus.cnt_mask    = 16'hFFFF;
      bus.win_sel     = 5'd4;

      // 1: reset values, then 64 quiet cycles
      repeat (2) @(posedge adc_clk);
      #1;
      check_all_zero("t1_reset");
      @(negedge adc_clk);
      rst_n = 1'b1;
      for (int w = 0; w < 4; w++) win16(16'h0000, 16'd0, 1'b0, "t1_quiet");

      // 2: flags on samples 3 and 15
      win16(16'h8008, 16'd2, 1'b1, "t2");
      win16(16'h0000, 16'd0, 1'b0, "t2_after");

      // 3: mask suppression, then mask hit
      bus.cnt_mask = 16'hFFF0;
      win16(16'h0421, 16'd3, 1'b0, "t3_masked");
      bus.cnt_mask = 16'h0001;
      win16(16'h0421, 16'd3, 1'b1, "t3_unmasked");

      // 4: full-size window saturates; mid-window win_sel change waits for the boundary
      bus.cnt_mask = 16'hFFFF;
      bus.win_sel  = 5'd16;
      for (int i = 0; i < 65536; i++) begin
         if (i == 100) bus.win_sel = 5'd4;
         tick(14'(i), 1'b1, 1'b0);
         if (i == 15) check_eq("t4_count_held", 32'(bus.ovfl_count), 32'd3);
         if (i < 65535 && (i % 4096 == 0 || i == 15 || i == 115))
            check_eq("t4_no_early_pulse", 32'(bus.ovfl_pulse), 32'd0);
      end
      check_eq("t4_sat_count", 32'(bus.ovfl_count), 32'hFFFF);
      check_eq("t4_sat_pulse", 32'(bus.ovfl_pulse), 32'd1);
      win16(16'h0001, 16'd1, 1'b1, "t4_next16");

      // 5: peak tracking
      tick(14'sd100, 1'b0, 1'b1);
      check_eq("t5_peak_clr100", 32'(bus.peak_abs), 32'd100);
      tick(-14'sd300, 1'b0, 1'b0);
      check_eq("t5_peak_neg300", 32'(bus.peak_abs), 32'd300);
      tick(14'sd200, 1'b0, 1'b0);
      check_eq("t5_peak_hold300", 32'(bus.peak_abs), 32'd300);
      tick(-14'sd8192, 1'b0, 1'b0);
      check_eq("t5_peak_min_sat", 32'(bus.peak_abs), 32'd8191);
      tick(14'sd50, 1'b0, 1'b1);
      check_eq("t5_peak_clr50", 32'(bus.peak_abs), 32'd50);
      tick(14'sd30, 1'b0, 1'b0);
      check_eq("t5_peak_hold50", 32'(bus.peak_abs), 32'd50);
      tick(-14'sd8191, 1'b0, 1'b0);
      check_eq("t5_peak_neg8191", 32'(bus.peak_abs), 32'd8191);

      // 6: async reset mid-window, then a full fresh window before any pulse
      for (int i = 0; i < 5; i++) tick(14'(i + 1), 1'b1, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("t6_async_reset");
      @(negedge adc_clk);
      rst_n = 1'b1;
      win16(16'hFFFF, 16'd16, 1'b1, "t6_fresh");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/adc_input_monitor.md
Name: adc_input_monitor

Overview:
- ADC front-end stage on the adc_clk domain, directly upstream of the receiver and of the overflow SYNC_PULSE.
- Registers raw ADC samples for the receiver.
- Counts ADC_OVFL assertions over a programmable sample window and flags a one-cycle overflow event when the masked count is non-zero.
- Tracks the peak absolute sample value for host readback.

Parameters:
ADC_BITS, 14, ADC sample width (signed, two's complement)
CTR_BITS, 16, overflow counter width; maximum window is 2^CTR_BITS samples

Ports:
adc_clk  in  1  ADC sample clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
adc_data_in  in  ADC_BITS  signed ADC sample, valid every cycle
adc_ovfl_in  in  1  ADC overrange flag for the same sample
cnt_mask  in  CTR_BITS  quasi-static; masks the window overflow count
win_sel  in  5  quasi-static; window length = 2^win_sel samples, clamped to the range [4, CTR_BITS]
peak_clr  in  1  single-cycle pulse; restarts peak tracking
adc_data_out  out  ADC_BITS  registered sample for the receiver
ovfl_pulse  out  1  one-cycle pulse at window end when (count & cnt_mask) != 0
ovfl_count  out  CTR_BITS  count from the last completed window, held
peak_abs  out  ADC_BITS-1  peak |sample| since the last clear, held

Behaviour:
- Reset (async assert, sync release by the caller): all outputs and all internal state are 0.
- Data path:
  - adc_data_out <= adc_data_in, giving 1 cycle of latency.
  - There is no other transformation.
- Window control:
  - At each window start, latch win_eff = clamp(win_sel, 4, CTR_BITS) into a register.
  - A change to win_sel mid-window takes effect only at the next window start.
  - Sample counter samp_ctr has CTR_BITS+1 bits and increments every cycle.
  - The window ends on the cycle where samp_ctr == 2^win_eff - 1.
  - On that cycle samp_ctr <= 0 and the next window begins.
- Overflow counting:
  - ovfl_acc increments when adc_ovfl_in = 1.
  - ovfl_acc saturates at 2^CTR_BITS - 1. An all-asserted full-size window would otherwise wrap.
- Window end cycle:
  - The final sample's flag is included in the count.
  - The included value is total = sat(ovfl_acc + adc_ovfl_in).
  - ovfl_count <= total.
  - ovfl_pulse <= ((total & cnt_mask) != 0).
  - ovfl_acc <= 0.
  - ovfl_pulse is registered, is high for exactly 1 cycle, and is 0 on all other cycles.
  - cnt_mask is sampled only on the window end cycle.
- Peak tracking:
  - abs_s = |adc_data_in|, except that -2^(ADC_BITS-1) saturates to 2^(ADC_BITS-1) - 1.
  - Normal cycle: peak_abs <= max(peak_abs, abs_s).
  - peak_clr cycle: peak_abs <= abs_s. The clear wins over the old peak, and the current sample is still captured, so no sample is lost.
  - peak_abs is independent of window timing.
- Latency summary:
  - Input sample to adc_data_out: 1 cycle.
  - Input sample to peak_abs: 1 cycle.
  - Last window sample to ovfl_pulse/ovfl_count: 1 cycle.
- Downstream use: ovfl_pulse feeds a SYNC_PULSE into cpu_clk, and window spacing of at least 16 cycles guarantees pulse separation.
- Quasi-static inputs: cnt_mask and win_sel are written from cpu_clk with no synchronizer. A mid-window change is tolerated because both are sampled only at window boundaries.

Decomposition:
- Shared package (kiwi.vh): ADC_BITS, the default CTR_BITS, WIN_SEL_MIN = 4, and the SET_CNT_MASK / SET_WIN_SEL op bits.
- One natural sub-module, ovfl_window_ctr: window counter, saturating accumulator, and the end-of-window compare.
- Peak tracking and data registering stay in the top module.

Test Plan:
1. Window count and reset values.
   - Stimulus: rst_n low, then release with win_sel=4, cnt_mask=16'hFFFF, adc_ovfl_in held 0.
   - Required response: all outputs 0 at reset; no ovfl_pulse for 64 cycles; ovfl_count stays 0.
2. Overflow flagged at window end.
   - Stimulus: win_sel=4; adc_ovfl_in high on samples 3 and 15 of the window, where 15 is the last sample.
   - Required response: ovfl_count=2 one cycle after sample 15; ovfl_pulse high for exactly that one cycle.
3. Mask suppression.
   - Stimulus: cnt_mask=16'hFFF0 with 3 overflows in a 16-sample window.
   - Required response: ovfl_count=3, ovfl_pulse stays 0.
   - Then cnt_mask=16'h0001 with the same stimulus: ovfl_pulse=1.
4. Saturation and window-change timing.
   - Stimulus: win_sel=16 with adc_ovfl_in held high for 65536 samples.
   - Required response: ovfl_count=16'hFFFF (saturated, not 0).
   - Stimulus: switch win_sel to 4 mid-window.
   - Required response: the current window still ends at sample 65535; the next window is 16 samples.
5. Peak tracking edge cases.
   - Stimulus: sample sequence 100, -300, 200 (ADC_BITS=14).
   - Required response: peak_abs ends at 300.
   - Stimulus: input -8192. Required response: peak_abs = 8191.
   - Stimulus: peak_clr coincident with sample 50. Required response: peak_abs = 50 on the next cycle.
6. Reset mid-operation and data path.
   - Stimulus: assert rst_n low mid-window, after some overflows have been counted.
   - Required response: outputs go to 0 asynchronously; after release, the first ovfl_pulse occurs only after a full new window.
   - Throughout: adc_data_out equals adc_data_in delayed by exactly 1 cycle.
